// File: rtl/ram1p1rwbe_sweep_if.sv
// Request/response bus for ram1p1rwbe_sweep: one request channel (read or
// byte-enabled write) and a read-response channel with no backpressure.
interface ram1p1rwbe_sweep_if #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 128
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    logic             ReqValid;
    logic             ReqReady;
    logic             ReqWrite;
    logic [AW-1:0]    ReqAdr;
    logic [WIDTH-1:0] ReqData;
    logic [NB-1:0]    ReqByteEn;
    logic             RspValid;
    logic [WIDTH-1:0] RspData;

    modport master (
        output ReqValid,
        input  ReqReady,
        output ReqWrite,
        output ReqAdr,
        output ReqData,
        output ReqByteEn,
        input  RspValid,
        input  RspData
    );

    modport slave (
        input  ReqValid,
        output ReqReady,
        input  ReqWrite,
        input  ReqAdr,
        input  ReqData,
        input  ReqByteEn,
        output RspValid,
        output RspData
    );
endinterface

// File: rtl/ram1p1rwbe_sweep.sv
// Single-port byte-enabled RAM that zero-fills itself after reset before accepting requests.
// Optional macro RAM_OUTREG_EN adds an output register stage (read latency 2 instead of 1).
module ram1p1rwbe_sweep #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    ram1p1rwbe_sweep_if.slave      bus,
    output logic                   InitDone
);
    localparam int          AW = $clog2(DEPTH);
    localparam int unsigned NB = WIDTH / 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    cnt, cnt_nxt;

    logic             mem_we;
    logic [AW-1:0]    mem_adr;
    logic [WIDTH-1:0] mem_wdata;
    logic [NB-1:0]    mem_be;
    logic             rd_en;
    logic             ready;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The sweep owns the single port during INIT; requests only reach it in RUN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_adr   = bus.ReqAdr;
        mem_wdata = bus.ReqData;
        mem_be    = bus.ReqByteEn;
        rd_en     = 1'b0;
        ready     = 1'b0;
        case (state)
            INIT: begin
                mem_we    = 1'b1;
                mem_adr   = cnt;
                mem_wdata = '0;
                mem_be    = '1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                ready = 1'b1;
                if (bus.ReqValid) begin
                    if (bus.ReqWrite) begin
                        mem_we = 1'b1;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem[mem_adr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data only updates on an accepted read, so it holds between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[mem_adr];
            end
        end
    end

`ifdef RAM_OUTREG_EN
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= rd_valid;
            if (rd_valid) begin
                out_data <= rd_data;
            end
        end
    end

    assign bus.RspValid = out_valid;
    assign bus.RspData  = out_data;
`else
    assign bus.RspValid = rd_valid;
    assign bus.RspData  = rd_data;
`endif

    assign bus.ReqReady = ready;
    assign InitDone     = (state == RUN);

endmodule

// File: tb/tb_ram1p1rwbe_sweep.sv
// Self-checking bench for ram1p1rwbe_sweep: scoreboard of expected read data and due cycle.
module tb_ram1p1rwbe_sweep;
    localparam int DEPTH = 64;
    localparam int WIDTH = 128;
    localparam int NB    = WIDTH / 8;
    localparam int AW    = $clog2(DEPTH);
`ifdef RAM_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic InitDone;

    ram1p1rwbe_sweep_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    ram1p1rwbe_sweep #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .InitDone (InitDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    exp_t             sb[$];
    exp_t             mon_e;
    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] last_rsp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            last_rsp = '0;
        end else if (bus.RspValid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp cyc=%0d RspData=%h required no response", cyc, bus.RspData);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (bus.RspData !== mon_e.data) begin
                    errors++;
                    $display("FAIL rsp_data cyc=%0d got %h expected %h", cyc, bus.RspData, mon_e.data);
                end
                checks++;
                if (cyc !== mon_e.due) begin
                    errors++;
                    $display("FAIL rsp_latency got cycle %0d expected cycle %0d", cyc, mon_e.due);
                end
            end
            last_rsp = bus.RspData;
        end else begin
            checks++;
            if (bus.RspData !== last_rsp) begin
                errors++;
                $display("FAIL rsp_hold cyc=%0d got %h expected %h", cyc, bus.RspData, last_rsp);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic wr(input int adr, input logic [WIDTH-1:0] data, input logic [NB-1:0] be);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = 1'b1;
        bus.ReqAdr    = AW'(adr);
        bus.ReqData   = data;
        bus.ReqByteEn = be;
        if (bus.ReqReady) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) model[adr][8*i +: 8] = data[8*i +: 8];
            end
        end
        @(negedge clk);
        bus.ReqValid = 1'b0;
    endtask

    task automatic rd_exp(input int adr, input logic [WIDTH-1:0] exp_data);
        exp_t e;
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = 1'b0;
        bus.ReqAdr    = AW'(adr);
        bus.ReqData   = {4{$urandom}};
        bus.ReqByteEn = NB'($urandom);
        if (bus.ReqReady) begin
            e.data = exp_data;
            e.due  = cyc + L;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.ReqValid = 1'b0;
    endtask

    task automatic rd(input int adr);
        rd_exp(adr, model[adr]);
    endtask

    task automatic drain();
        int n = 0;
        bus.ReqValid = 1'b0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Call exactly at the negedge where reset is released; requests driven for the
    // first pre_valid cycles must be ignored by the INIT state.
    task automatic wait_init(input int pre_valid);
        int n = 0;
        while (bus.ReqReady === 1'b0 && n < 200) begin
            bus.ReqValid  = (n < pre_valid);
            bus.ReqWrite  = n[0];
            bus.ReqAdr    = AW'(n);
            bus.ReqData   = '1;
            bus.ReqByteEn = '1;
            n++;
            @(negedge clk);
        end
        bus.ReqValid = 1'b0;
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL init_cycles got %0d expected %0d", n, DEPTH);
        end
        checks++;
        if (InitDone !== 1'b1) begin
            errors++;
            $display("FAIL init_done got %b expected 1", InitDone);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.ReqReady !== 1'b0 || InitDone !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_done got ReqReady=%b InitDone=%b expected 0 0", tag, bus.ReqReady, InitDone);
        end
        checks++;
        if (bus.RspValid !== 1'b0 || bus.RspData !== '0) begin
            errors++;
            $display("FAIL %s_rsp got RspValid=%b RspData=%h expected 0 0", tag, bus.RspValid, bus.RspData);
        end
    endtask

    task automatic apply_reset();
        #1 reset = 1'b1;
        sb.delete();
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        bus.ReqValid  = 1'b0;
        bus.ReqWrite  = 1'b0;
        bus.ReqAdr    = '0;
        bus.ReqData   = '0;
        bus.ReqByteEn = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        model_clear();
        wait_init(20);
    endtask

    task automatic test_sweep_zero();
        for (int a = 0; a < DEPTH; a++) rd_exp(a, '0);
        drain();
    endtask

    task automatic test_byte_enable();
        logic [WIDTH-1:0] want;
        want = {{12{8'hAA}}, {4{8'h55}}};
        wr(5, {NB{8'hAA}}, '1);
        wr(5, {NB{8'h55}}, NB'(16'h000F));
        rd_exp(5, want);
        drain();
        for (int i = 0; i < 12; i++) begin
            int a;
            a = $urandom_range(0, DEPTH - 1);
            wr(a, {$urandom, $urandom, $urandom, $urandom}, NB'($urandom));
            rd(a);
        end
        drain();
    endtask

    task automatic test_raw();
        wr(3, 128'h1234, '1);
        rd_exp(3, 128'h1234);
        drain();
    endtask

    task automatic test_be_zero();
        wr(7, 128'hCAFE_F00D_0123_4567_89AB_CDEF_DEAD_BEEF, '1);
        wr(7, '1, '0);
        rd_exp(7, 128'hCAFE_F00D_0123_4567_89AB_CDEF_DEAD_BEEF);
        drain();
    endtask

    task automatic test_back_to_back();
        wr(0, 128'h1111, '1);
        wr(1, 128'h2222, '1);
        wr(2, 128'h3333, '1);
        rd_exp(0, 128'h1111);
        rd_exp(1, 128'h2222);
        rd_exp(2, 128'h3333);
        drain();
        for (int i = 0; i < 40; i++) begin
            int a;
            a = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 1) == 1) wr(a, {$urandom, $urandom, $urandom, $urandom}, NB'($urandom));
            else rd(a);
        end
        drain();
    endtask

    task automatic test_reset_run();
        wr(63, {NB{8'h5A}}, '1);
        // Read accepted, then reset before the response appears: it must be dropped.
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b0;
        bus.ReqAdr   = AW'(63);
        @(posedge clk);
        #1 reset = 1'b1;
        bus.ReqValid = 1'b0;
        #1 check_reset_outputs("inflight");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        wait_init(0);
        rd_exp(63, '0);
        drain();

        apply_reset();
        repeat (10) @(negedge clk);
        checks++;
        if (bus.ReqReady !== 1'b0) begin
            errors++;
            $display("FAIL init_mid_ready got %b expected 0", bus.ReqReady);
        end
        apply_reset();
        wait_init(0);
        rd_exp(10, '0);
        drain();
    endtask

    initial begin
        test_reset();
        test_sweep_zero();
        test_byte_enable();
        test_raw();
        test_be_zero();
        test_back_to_back();
        test_reset_run();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
